// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//   Memory + write-back stage that sits directly after execute. ALU results
//   (ADD/INC) go straight to the register-file write port one cycle after
//   capture. LOAD/STORE use a small multi-cycle data memory. The upstream
//   stage is held off via stall_req while the memory is busy. Retired
//   instructions are counted.
//
// Ports
//   clk            in   stage clock
//   resetn         in   asynchronous active-low reset
//   ex_valid       in   EX/MEM holds a valid instruction this cycle
//   ex_opcode      in   001 ADD, 011 INC, 100 LOAD, 101 STORE, other = NOP
//   ex_result      in   ALU result (ADD/INC) or memory address (LOAD/STORE)
//   ex_store_data  in   STORE data
//   ex_wb_enc      in   destination register encoding
//   flush          in   synchronous squash request
//   stall_req      out  upstream must hold EX/MEM fields while high
//   we             out  register-file write enable
//   r_write_enc    out  register-file write register encoding
//   wdata          out  register-file write data
//   retired_count  out  completed-instruction count (wraps)
// ---------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ex_valid,
    input  logic [2:0]        ex_opcode,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [1:0]        ex_wb_enc,
    input  logic              flush,
    output logic              stall_req,
    output logic              we,
    output logic [1:0]        r_write_enc,
    output logic [DATA_W-1:0] wdata,
    output logic [CNT_W-1:0]  retired_count
);

    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_INC   = 3'b011;
    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_STORE = 3'b101;

    // Access counter only needs to reach MEM_LAT-1.
    localparam int               LAT_CW   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_CW-1:0] LAT_LAST = LAT_CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WB     = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [LAT_CW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   sdata_q, sdata_d;
    logic [1:0]          dest_q, dest_d;
    logic                is_store_q, is_store_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          wenc_q, wenc_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_q [2**ADDR_W];

    // -----------------------------------------------------------------------
    // Next-state / datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        dest_d     = dest_q;
        is_store_d = is_store_q;
        wdata_d    = wdata_q;
        wenc_d     = wenc_q;
        retired_d  = retired_q;
        mem_we     = 1'b0;

        unique case (state_q)
            IDLE, WB: begin
                // A write-back lasts one cycle; without a new capture we drop to IDLE.
                state_d = IDLE;
                if (ex_valid && !flush) begin
                    unique case (ex_opcode)
                        OP_ADD, OP_INC: begin
                            state_d = WB;
                            wdata_d = ex_result;
                            wenc_d  = ex_wb_enc;
                        end
                        OP_LOAD, OP_STORE: begin
                            state_d    = ACCESS;
                            addr_d     = ex_result[ADDR_W-1:0];
                            sdata_d    = ex_store_data;
                            dest_d     = ex_wb_enc;
                            is_store_d = (ex_opcode == OP_STORE);
                            cnt_d      = '0;
                        end
                        default: ;
                    endcase
                end
            end

            ACCESS: begin
                if (flush && !is_store_q) begin
                    // A LOAD can still be squashed; a captured STORE cannot.
                    state_d = IDLE;
                end else if (cnt_q == LAT_LAST) begin
                    if (is_store_q) begin
                        mem_we    = 1'b1;
                        retired_d = retired_q + CNT_W'(1);
                        state_d   = IDLE;
                    end else begin
                        wdata_d = mem_q[addr_q];
                        wenc_d  = dest_q;
                        state_d = WB;
                    end
                end else begin
                    cnt_d = cnt_q + LAT_CW'(1);
                end
            end

            default: state_d = IDLE;
        endcase

        // Every entry into WB (ALU op or LOAD completion) is one retirement.
        if (state_d == WB) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // State and memory registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            sdata_q    <= '0;
            dest_q     <= '0;
            is_store_q <= 1'b0;
            wdata_q    <= '0;
            wenc_q     <= '0;
            retired_q  <= '0;
            // NOTE: the data memory must read back zero after reset, so it is
            // built from resettable flops rather than an inferred RAM macro.
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            dest_q     <= dest_d;
            is_store_q <= is_store_d;
            wdata_q    <= wdata_d;
            wenc_q     <= wenc_d;
            retired_q  <= retired_d;
            if (mem_we) begin
                mem_q[addr_q] <= sdata_q;
            end
        end
    end

    assign stall_req     = (state_q == ACCESS);
    assign we            = (state_q == WB);
    assign r_write_enc   = wenc_q;
    assign wdata         = wdata_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
//   Bench for mem_wb_stage. A second instance with CNT_W=2 shares every
//   input so the retired-count wrap can be observed. Expected values come
//   from hand-written vector tables and a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 4;
    localparam int MEM_LAT = 2;
    localparam int CNT_W   = 16;

    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_INC   = 3'b011;
    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_STORE = 3'b101;
    localparam logic [2:0] OP_BAD   = 3'b111;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              ex_valid = 1'b0;
    logic [2:0]        ex_opcode = '0;
    logic [DATA_W-1:0] ex_result = '0;
    logic [DATA_W-1:0] ex_store_data = '0;
    logic [1:0]        ex_wb_enc = '0;
    logic              flush = 1'b0;

    logic              stall_req, we;
    logic [1:0]        r_write_enc;
    logic [DATA_W-1:0] wdata;
    logic [CNT_W-1:0]  retired_count;

    logic              c2_stall_req, c2_we;
    logic [1:0]        c2_r_write_enc;
    logic [DATA_W-1:0] c2_wdata;
    logic [1:0]        c2_retired_count;

    mem_wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_wb_enc(ex_wb_enc),
        .flush(flush), .stall_req(stall_req), .we(we), .r_write_enc(r_write_enc),
        .wdata(wdata), .retired_count(retired_count)
    );

    mem_wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .CNT_W(2)) dut_c2 (
        .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_wb_enc(ex_wb_enc),
        .flush(flush), .stall_req(c2_stall_req), .we(c2_we), .r_write_enc(c2_r_write_enc),
        .wdata(c2_wdata), .retired_count(c2_retired_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: one pending memory operation with a countdown of
    // remaining busy cycles, a plain array for memory, an integer count.
    // -----------------------------------------------------------------------
    int          m_busy_left;
    logic        m_is_store;
    int          m_addr;
    logic [31:0] m_data;
    logic [1:0]  m_dest;
    logic [31:0] m_mem [16];
    logic        m_we;
    logic [31:0] m_wdata;
    logic [1:0]  m_enc;
    int          m_count;

    function automatic void model_reset();
        m_busy_left = 0;
        m_is_store  = 1'b0;
        m_addr      = 0;
        m_data      = '0;
        m_dest      = '0;
        m_we        = 1'b0;
        m_wdata     = '0;
        m_enc       = '0;
        m_count     = 0;
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
    endfunction

    // Advance the model by one clock edge using the inputs present before it.
    function automatic void model_step();
        if (m_busy_left > 0) begin
            m_we = 1'b0;
            if (flush && !m_is_store) begin
                m_busy_left = 0;
            end else if (m_busy_left == 1) begin
                m_busy_left = 0;
                m_count++;
                if (m_is_store) begin
                    m_mem[m_addr] = m_data;
                end else begin
                    m_we    = 1'b1;
                    m_wdata = m_mem[m_addr];
                    m_enc   = m_dest;
                end
            end else begin
                m_busy_left--;
            end
        end else begin
            m_we = 1'b0;
            if (ex_valid && !flush) begin
                if (ex_opcode == OP_ADD || ex_opcode == OP_INC) begin
                    m_we    = 1'b1;
                    m_wdata = ex_result;
                    m_enc   = ex_wb_enc;
                    m_count++;
                end else if (ex_opcode == OP_LOAD || ex_opcode == OP_STORE) begin
                    m_busy_left = MEM_LAT;
                    m_is_store  = (ex_opcode == OP_STORE);
                    m_addr      = int'(ex_result % 16);
                    m_data      = ex_store_data;
                    m_dest      = ex_wb_enc;
                end
            end
        end
    endfunction

    task automatic check_model(input string tag);
        logic [15:0] c16;
        logic [15:0] c_all;
        c_all = 16'(m_count);
        c16   = c_all;
        check({tag, ".stall_req"}, 64'(stall_req), 64'(m_busy_left > 0));
        check({tag, ".we"}, 64'(we), 64'(m_we));
        check({tag, ".r_write_enc"}, 64'(r_write_enc), 64'(m_enc));
        check({tag, ".wdata"}, 64'(wdata), 64'(m_wdata));
        check({tag, ".retired_count"}, 64'(retired_count), 64'(c16));
        check({tag, ".retired_count_w2"}, 64'(c2_retired_count), 64'(c16[1:0]));
    endtask

    // Drive one cycle of inputs, take the clock edge, advance the model.
    task automatic apply(input logic v, input logic [2:0] op, input logic [31:0] res,
                         input logic [31:0] sd, input logic [1:0] enc, input logic fl);
        ex_valid      = v;
        ex_opcode     = op;
        ex_result     = res;
        ex_store_data = sd;
        ex_wb_enc     = enc;
        flush         = fl;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        ex_valid = 1'b0;
        flush    = 1'b0;
        resetn   = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // -----------------------------------------------------------------------
    // Vector table: one row per cycle, expectations written by hand.
    // -----------------------------------------------------------------------
    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic [31:0] res;
        logic [31:0] sd;
        logic [1:0]  enc;
        logic        fl;
        logic        e_we;
        logic        e_stall;
        logic [31:0] e_wdata;
        logic [1:0]  e_enc;
        logic [15:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [2:0] op, input logic [31:0] res,
                                input logic [31:0] sd, input logic [1:0] enc, input logic fl,
                                input logic e_we, input logic e_stall, input logic [31:0] e_wdata,
                                input logic [1:0] e_enc, input logic [15:0] e_cnt);
        vec_t r;
        r.v = v; r.op = op; r.res = res; r.sd = sd; r.enc = enc; r.fl = fl;
        r.e_we = e_we; r.e_stall = e_stall; r.e_wdata = e_wdata; r.e_enc = e_enc; r.e_cnt = e_cnt;
        return r;
    endfunction

    vec_t tbl [13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] e;
        logic [1:0]  e2;
        int          stall_seen;

        //              v  op        res           sd            enc   fl   we stall wdata         enc   cnt
        tbl[0]  = mk(1, OP_ADD,   32'h5,        32'h0,        2'b01, 0,   1, 0, 32'h5,        2'b01, 16'd1);
        tbl[1]  = mk(1, OP_STORE, 32'h3,        32'hDEADBEEF, 2'b10, 0,   0, 1, 32'h5,        2'b01, 16'd1);
        tbl[2]  = mk(1, OP_LOAD,  32'h13,       32'h0,        2'b00, 0,   0, 1, 32'h5,        2'b01, 16'd1);
        tbl[3]  = mk(1, OP_LOAD,  32'h13,       32'h0,        2'b00, 0,   0, 0, 32'h5,        2'b01, 16'd2);
        tbl[4]  = mk(1, OP_LOAD,  32'h13,       32'h0,        2'b00, 0,   0, 1, 32'h5,        2'b01, 16'd2);
        tbl[5]  = mk(0, OP_LOAD,  32'h13,       32'h0,        2'b00, 0,   0, 1, 32'h5,        2'b01, 16'd2);
        tbl[6]  = mk(0, OP_ADD,   32'h0,        32'h0,        2'b00, 0,   1, 0, 32'hDEADBEEF, 2'b00, 16'd3);
        tbl[7]  = mk(1, OP_INC,   32'h7,        32'h0,        2'b11, 0,   1, 0, 32'h7,        2'b11, 16'd4);
        tbl[8]  = mk(1, OP_INC,   32'h8,        32'h0,        2'b10, 0,   1, 0, 32'h8,        2'b10, 16'd5);
        tbl[9]  = mk(1, OP_INC,   32'h9,        32'h0,        2'b01, 0,   1, 0, 32'h9,        2'b01, 16'd6);
        tbl[10] = mk(1, OP_BAD,   32'hAA,       32'h0,        2'b11, 0,   0, 0, 32'h9,        2'b01, 16'd6);
        tbl[11] = mk(1, OP_ADD,   32'hBB,       32'h0,        2'b11, 1,   0, 0, 32'h9,        2'b01, 16'd6);
        tbl[12] = mk(0, OP_ADD,   32'hCC,       32'h0,        2'b11, 0,   0, 0, 32'h9,        2'b01, 16'd6);

        // ---- Reset state --------------------------------------------------
        do_reset();
        #1;
        check("reset.stall_req", 64'(stall_req), 64'h0);
        check("reset.we", 64'(we), 64'h0);
        check("reset.r_write_enc", 64'(r_write_enc), 64'h0);
        check("reset.wdata", 64'(wdata), 64'h0);
        check("reset.retired_count", 64'(retired_count), 64'h0);

        // ---- Reset in the middle of a STORE access -------------------------
        apply(1, OP_STORE, 32'h2, 32'hAAAA5555, 2'b00, 0);
        check("rst_mid.stall_before", 64'(stall_req), 64'h1);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check("rst_mid.stall_req", 64'(stall_req), 64'h0);
        check("rst_mid.we", 64'(we), 64'h0);
        check("rst_mid.retired_count", 64'(retired_count), 64'h0);
        @(negedge clk);
        resetn = 1'b1;
        apply(1, OP_LOAD, 32'hF2, 32'h0, 2'b11, 0);   // upper address bits ignored -> addr 2
        apply(0, OP_ADD, 32'h0, 32'h0, 2'b00, 0);
        apply(0, OP_ADD, 32'h0, 32'h0, 2'b00, 0);
        check("rst_mid.load_we", 64'(we), 64'h1);
        check("rst_mid.load_wdata", 64'(wdata), 64'h0);
        check_model("rst_mid");

        // ---- Table-driven sequence -----------------------------------------
        do_reset();
        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].v, tbl[i].op, tbl[i].res, tbl[i].sd, tbl[i].enc, tbl[i].fl);
            e  = tbl[i].e_cnt;
            e2 = e[1:0];
            check($sformatf("tbl[%0d].we", i), 64'(we), 64'(tbl[i].e_we));
            check($sformatf("tbl[%0d].stall_req", i), 64'(stall_req), 64'(tbl[i].e_stall));
            check($sformatf("tbl[%0d].wdata", i), 64'(wdata), 64'(tbl[i].e_wdata));
            check($sformatf("tbl[%0d].r_write_enc", i), 64'(r_write_enc), 64'(tbl[i].e_enc));
            check($sformatf("tbl[%0d].retired_count", i), 64'(retired_count), 64'(e));
            check($sformatf("tbl[%0d].retired_count_w2", i), 64'(c2_retired_count), 64'(e2));
        end

        // ---- Flush during ACCESS --------------------------------------------
        do_reset();
        apply(1, OP_STORE, 32'h3, 32'h0BADF00D, 2'b00, 0);
        apply(0, OP_ADD, 32'h0, 32'h0, 2'b00, 0);
        apply(0, OP_ADD, 32'h0, 32'h0, 2'b00, 0);
        check_model("fl.pre_store");
        apply(1, OP_LOAD, 32'h3, 32'h0, 2'b10, 0);
        apply(0, OP_ADD, 32'h0, 32'h0, 2'b00, 1);      // squash the LOAD
        check("fl.load.stall_req", 64'(stall_req), 64'h0);
        check("fl.load.we", 64'(we), 64'h0);
        check("fl.load.retired_count", 64'(retired_count), 64'h1);
        apply(0, OP_ADD, 32'h0, 32'h0, 2'b00, 0);
        check("fl.load.we_later", 64'(we), 64'h0);
        apply(1, OP_STORE, 32'h1, 32'h12345678, 2'b00, 0);
        apply(0, OP_ADD, 32'h0, 32'h0, 2'b00, 1);      // flush cannot stop a STORE
        check("fl.store.stall_held", 64'(stall_req), 64'h1);
        apply(0, OP_ADD, 32'h0, 32'h0, 2'b00, 1);
        check("fl.store.retired_count", 64'(retired_count), 64'h2);
        apply(1, OP_LOAD, 32'h1, 32'h0, 2'b01, 0);
        apply(0, OP_ADD, 32'h0, 32'h0, 2'b00, 0);
        apply(0, OP_ADD, 32'h0, 32'h0, 2'b00, 0);
        check("fl.store.readback", 64'(wdata), 64'h12345678);
        check_model("fl.end");

        // ---- Back-to-back INC: no stall ever -------------------------------
        do_reset();
        stall_seen = 0;
        for (int i = 0; i < 3; i++) begin
            apply(1, OP_INC, 32'(i + 100), 32'h0, 2'(i), 0);
            check($sformatf("b2b[%0d].we", i), 64'(we), 64'h1);
            if (stall_req) stall_seen++;
        end
        apply(0, OP_ADD, 32'h0, 32'h0, 2'b00, 0);
        check("b2b.we_after", 64'(we), 64'h0);
        check("b2b.stall_cycles", 64'(stall_seen), 64'h0);

        // ---- Count wrap on the CNT_W=2 instance ----------------------------
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(1, OP_ADD, 32'(i), 32'h0, 2'b01, 0);
        end
        check("wrap.retired_count_w2", 64'(c2_retired_count), 64'h1);
        check("wrap.retired_count", 64'(retired_count), 64'h5);
        apply(1, OP_BAD, 32'h77, 32'h0, 2'b01, 0);
        check("wrap.bad_op_we", 64'(c2_we), 64'h0);
        check("wrap.bad_op_count_w2", 64'(c2_retired_count), 64'h1);

        // ---- Randomized traffic against the reference model ----------------
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic        v;
            logic        fl;
            logic [2:0]  op;
            v  = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 7) == 0);
            op = 3'($urandom_range(0, 7));
            apply(v, op, $urandom(), $urandom(), 2'($urandom_range(0, 3)), fl);
            check_model($sformatf("rnd[%0d]", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
